mem_arbiter: RTL and testbench

//  Arbitrates the single-ported RAM between the fetch stage (iREN) and the

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the load/store path.
// Data wins ties, bounded by a fetch starvation guard; a watchdog flags a silent RAM.
module mem_arbiter #(
   parameter int unsigned DLIMIT   = 4,
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ram_ren,
   output logic        ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_rdy,
   output logic        err
);

   localparam int unsigned CW = $clog2(DLIMIT + 1);
   localparam logic [CW-1:0] DL = CW'(DLIMIT);
   localparam logic [7:0] WM = 8'(WAIT_MAX);

   typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_dcnt;
   logic [7:0]    r_wdog;
   logic          r_err;
   logic          r_ren;
   logic          r_wen;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;

   logic w_dreq;
   logic w_dwin;
   logic w_icomp;
   logic w_dcomp;
   logic w_tout;

   assign w_dreq  = dREN | dWEN;
   assign w_dwin  = w_dreq && (!iREN || (r_dcnt < DL));
   // a requester that dropped its enable never completes, even on ram_rdy
   assign w_icomp = (r_state == IGNT) && iREN && ram_rdy;
   assign w_dcomp = (r_state == DGNT) && w_dreq && ram_rdy;
   assign w_tout  = (r_state != IDLE) && !ram_rdy && (r_wdog == WM);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_dwin)    w_next = DGNT;
            else if (iREN) w_next = IGNT;
            else           w_next = IDLE;
         end
         IGNT: begin
            if (!iREN || ram_rdy || w_tout) w_next = IDLE;
         end
         DGNT: begin
            if (!w_dreq || ram_rdy || w_tout) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      iwait     = iREN && !w_icomp;
      dwait     = w_dreq && !w_dcomp;
      iload     = w_icomp ? ram_rdata : 32'h0;
      dload     = w_dcomp ? ram_rdata : 32'h0;
      ram_ren   = r_ren;
      ram_wen   = r_wen;
      ram_addr  = r_addr;
      ram_wdata = r_wdata;
      err       = r_err;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_wdog  <= 8'h0;
      end else if (r_state == IDLE) begin
         // wdog holds the number of grant cycles including the current one
         r_wdog <= (w_next != IDLE) ? 8'd1 : 8'd0;
         if (w_next == DGNT) begin
            r_addr  <= daddr;
            r_wdata <= dstore;
            r_ren   <= !dWEN;
            r_wen   <= dWEN;
         end else if (w_next == IGNT) begin
            r_addr  <= iaddr;
            r_ren   <= 1'b1;
            r_wen   <= 1'b0;
         end
      end else if (w_next == IDLE) begin
         r_ren  <= 1'b0;
         r_wen  <= 1'b0;
         r_wdog <= 8'h0;
      end else begin
         r_wdog <= r_wdog + 8'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_dcnt <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_tout) r_err <= 1'b1;
         if (w_dcomp) begin
            if (!iREN)            r_dcnt <= '0;
            else if (r_dcnt < DL) r_dcnt <= r_dcnt + 1'b1;
         end else if (w_icomp) begin
            r_dcnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted requesters, a latency-programmable RAM
// responder and per-requester scoreboards of expected completion data.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = 32'h0;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = 32'h0;
   logic [31:0] dstore = 32'h0;
   logic        dwait;
   logic [31:0] dload;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'h0;
   logic        ram_rdy = 1'b0;
   logic        err;

   mem_arbiter #(.DLIMIT(4), .WAIT_MAX(8)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rdy(ram_rdy),
      .err(err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } dreq_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] iq[$];
   dreq_t       dq[$];
   logic [31:0] sb_i[$];
   logic [31:0] sb_d[$];
   byte         ord_log[$];

   bit i_comp = 1'b0;
   bit d_comp = 1'b0;
   int rcnt = 0;
   int ram_lat = 1;
   bit ram_on = 1'b1;

   function automatic logic [31:0] rfn(input logic [31:0] a);
      return a ^ 32'h2408_004A;
   endfunction

   task automatic start_i();
      iaddr = iq.pop_front();
      iREN  = 1'b1;
      sb_i.push_back(rfn(iaddr));
   endtask

   task automatic start_d();
      dreq_t r;
      r = dq.pop_front();
      daddr  = r.addr;
      dstore = r.data;
      dWEN   = r.wr;
      dREN   = !r.wr;
      sb_d.push_back(r.wr ? r.data : rfn(r.addr));
   endtask

   task automatic kick();
      if (!iREN && iq.size() > 0) start_i();
      if (!dREN && !dWEN && dq.size() > 0) start_d();
   endtask

   // Negedge: detect completions and score them against the queues.
   task automatic sample();
      logic [31:0] e;
      @(negedge CLK);
      i_comp = iREN && !iwait;
      d_comp = (dREN || dWEN) && !dwait;
      if (i_comp) begin
         ord_log.push_back("I");
         n_checks++;
         if (sb_i.size() == 0) begin
            n_fail++;
            $display("FAIL sb_fetch: unexpected completion iload=%h", iload);
         end else begin
            e = sb_i.pop_front();
            if (iload !== e) begin
               n_fail++;
               $display("FAIL sb_fetch: iload=%h expected %h", iload, e);
            end
         end
      end
      if (d_comp) begin
         ord_log.push_back("D");
         n_checks++;
         if (sb_d.size() == 0) begin
            n_fail++;
            $display("FAIL sb_data: unexpected completion dload=%h", dload);
         end else begin
            e = sb_d.pop_front();
            if (dWEN) begin
               if (ram_wen !== 1'b1 || ram_wdata !== e) begin
                  n_fail++;
                  $display("FAIL sb_store: wen=%b wdata=%h expected 1 %h",
                           ram_wen, ram_wdata, e);
               end
            end else if (dload !== e) begin
               n_fail++;
               $display("FAIL sb_load: dload=%h expected %h", dload, e);
            end
         end
      end
   endtask

   // Posedge+1: RAM responder, then requesters retire or re-issue.
   task automatic advance();
      @(posedge CLK);
      #1;
      if (!RST && (ram_ren || ram_wen)) rcnt++;
      else rcnt = 0;
      ram_rdy   = ram_on && (rcnt != 0) && (rcnt == ram_lat);
      ram_rdata = ram_rdy ? rfn(ram_addr) : 32'h0;
      if (i_comp) begin
         i_comp = 1'b0;
         if (iq.size() > 0) start_i();
         else iREN = 1'b0;
      end
      if (d_comp) begin
         d_comp = 1'b0;
         dREN = 1'b0;
         dWEN = 1'b0;
         if (dq.size() > 0) start_d();
      end
   endtask

   task automatic run_idle(input int budget);
      int k = 0;
      while ((iREN || dREN || dWEN || iq.size() > 0 || dq.size() > 0) && k < budget) begin
         kick();
         sample();
         advance();
         k++;
      end
      n_checks++;
      if (iREN || dREN || dWEN) begin
         n_fail++;
         $display("FAIL run_idle: requests still pending after %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      RST  = 1'b1;
      iREN = 1'b1;
      dWEN = 1'b1;
      sample();
      n_checks++;
      if ({ram_ren, ram_wen, err} !== 3'b000 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_regs: ren=%b wen=%b err=%b addr=%h wdata=%h expected all 0",
                  ram_ren, ram_wen, err, ram_addr, ram_wdata);
      end
      n_checks++;
      if (iwait !== 1'b1 || dwait !== 1'b1 || iload !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_waits: iwait=%b dwait=%b iload=%h expected 1 1 0",
                  iwait, dwait, iload);
      end
      advance();
      RST  = 1'b0;
      iREN = 1'b0;
      dWEN = 1'b0;
      sample();
      n_checks++;
      if (iwait !== 1'b0 || dwait !== 1'b0 || ram_ren !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_quiet: iwait=%b dwait=%b ren=%b expected 0 0 0",
                  iwait, dwait, ram_ren);
      end
      advance();
   endtask

   task automatic test_fetch();
      ram_lat = 3;
      iq.push_back(32'h40);
      kick();
      for (int c = 0; c <= 4; c++) begin
         sample();
         n_checks++;
         if (ram_ren !== ((c >= 1 && c <= 3) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL fetch_ren c%0d: ram_ren=%b", c, ram_ren);
         end
         if (c == 1) begin
            n_checks++;
            if (ram_addr !== 32'h40 || ram_wen !== 1'b0) begin
               n_fail++;
               $display("FAIL fetch_addr: addr=%h wen=%b expected 00000040 0", ram_addr, ram_wen);
            end
         end
         if (c == 3) begin
            n_checks++;
            if (iwait !== 1'b0 || iload !== 32'h2408000A) begin
               n_fail++;
               $display("FAIL fetch_done: iwait=%b iload=%h expected 0 2408000a", iwait, iload);
            end
         end
         advance();
      end
   endtask

   task automatic test_tie();
      dreq_t r;
      ram_lat = 1;
      ord_log.delete();
      r = '{wr: 1'b0, addr: 32'h100, data: 32'h0};
      iq.push_back(32'h80);
      dq.push_back(r);
      kick();
      for (int c = 0; c <= 3; c++) begin
         sample();
         if (c == 1) begin
            n_checks++;
            if (ram_addr !== 32'h100 || ram_ren !== 1'b1) begin
               n_fail++;
               $display("FAIL tie_dfirst: addr=%h ren=%b expected 00000100 1", ram_addr, ram_ren);
            end
         end
         if (c == 3) begin
            n_checks++;
            if (ram_addr !== 32'h80 || ram_ren !== 1'b1) begin
               n_fail++;
               $display("FAIL tie_ithen: addr=%h ren=%b expected 00000080 1", ram_addr, ram_ren);
            end
         end
         advance();
      end
      n_checks++;
      if (ord_log.size() != 2 || ord_log[0] != "D" || ord_log[1] != "I") begin
         n_fail++;
         $display("FAIL tie_order: %0d completions, expected D then I", ord_log.size());
      end
   endtask

   task automatic test_starve();
      string exp_ord = "DDDDIDD";
      dreq_t r;
      ram_lat = 1;
      ord_log.delete();
      for (int k = 0; k < 6; k++) begin
         r = '{wr: 1'b1, addr: 32'h300 + 32'(4 * k), data: 32'hA000_0000 + 32'(k)};
         dq.push_back(r);
      end
      iq.push_back(32'h500);
      run_idle(60);
      n_checks++;
      if (ord_log.size() != 7) begin
         n_fail++;
         $display("FAIL starve_count: %0d completions expected 7", ord_log.size());
      end else begin
         for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (ord_log[k] != exp_ord[k]) begin
               n_fail++;
               $display("FAIL starve_order[%0d]: got %c expected %c", k, ord_log[k], exp_ord[k]);
            end
         end
      end
   endtask

   task automatic test_store();
      dreq_t r;
      ram_lat = 2;
      r = '{wr: 1'b1, addr: 32'h200, data: 32'hDEADBEEF};
      dq.push_back(r);
      kick();
      sample();
      advance();
      sample();
      n_checks++;
      if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_wdata !== 32'hDEADBEEF ||
          ram_addr !== 32'h200 || dwait !== 1'b1) begin
         n_fail++;
         $display("FAIL store_grant: wen=%b ren=%b wdata=%h addr=%h dwait=%b expected 1 0 deadbeef 00000200 1",
                  ram_wen, ram_ren, ram_wdata, ram_addr, dwait);
      end
      advance();
      daddr  = 32'h0000_0FFF;
      dstore = 32'h0;
      sample();
      n_checks++;
      if (dwait !== 1'b0 || ram_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL store_done: dwait=%b addr=%h expected 0 00000200", dwait, ram_addr);
      end
      advance();
      sample();
      n_checks++;
      if (ram_wen !== 1'b0) begin
         n_fail++;
         $display("FAIL store_release: wen=%b expected 0", ram_wen);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      int done = 0;
      ram_lat = 1;
      iq.push_back(32'h900);
      iq.push_back(32'h904);
      iq.push_back(32'h908);
      kick();
      for (int c = 0; c < 6; c++) begin
         sample();
         if (i_comp) done++;
         advance();
      end
      n_checks++;
      if (done != 3 || iREN !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_rate: %0d fetches in 6 cycles, expected 3", done);
      end
   endtask

   task automatic test_timeout();
      dreq_t r;
      ram_on = 1'b0;
      iq.push_back(32'h600);
      kick();
      sample();
      advance();
      for (int c = 1; c <= 8; c++) begin
         sample();
         n_checks++;
         if (ram_ren !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL tout_wait c%0d: ren=%b err=%b expected 1 0", c, ram_ren, err);
         end
         advance();
      end
      sample();
      n_checks++;
      if (ram_ren !== 1'b0 || err !== 1'b1 || iwait !== 1'b1) begin
         n_fail++;
         $display("FAIL tout_flag: ren=%b err=%b iwait=%b expected 0 1 1", ram_ren, err, iwait);
      end
      ram_on  = 1'b1;
      ram_lat = 2;
      advance();
      sample();
      n_checks++;
      if (ram_ren !== 1'b1) begin
         n_fail++;
         $display("FAIL tout_regrant: ren=%b expected 1", ram_ren);
      end
      advance();
      run_idle(20);
      r = '{wr: 1'b0, addr: 32'h640, data: 32'h0};
      dq.push_back(r);
      run_idle(20);
      sample();
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL tout_sticky: err=%b expected 1", err);
      end
      advance();
   endtask

   task automatic test_abort();
      dreq_t r;
      ram_lat = 3;
      daddr = 32'h700;
      dREN  = 1'b1;
      sample();
      advance();
      sample();
      n_checks++;
      if (ram_ren !== 1'b1 || ram_addr !== 32'h700) begin
         n_fail++;
         $display("FAIL abort_grant: ren=%b addr=%h expected 1 00000700", ram_ren, ram_addr);
      end
      advance();
      sample();
      advance();
      dREN = 1'b0;
      sample();
      n_checks++;
      if (dload !== 32'h0 || dwait !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_rdy: dload=%h dwait=%b expected 0 0", dload, dwait);
      end
      advance();
      sample();
      n_checks++;
      if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_drop: ren=%b wen=%b expected 0 0", ram_ren, ram_wen);
      end
      advance();
      ram_lat = 1;
      r = '{wr: 1'b0, addr: 32'h720, data: 32'h0};
      dq.push_back(r);
      run_idle(20);
   endtask

   task automatic test_rst_mid();
      ram_lat = 10;
      iaddr = 32'h800;
      iREN  = 1'b1;
      sample();
      advance();
      sample();
      n_checks++;
      if (ram_ren !== 1'b1 || ram_addr !== 32'h800) begin
         n_fail++;
         $display("FAIL rst_grant: ren=%b addr=%h expected 1 00000800", ram_ren, ram_addr);
      end
      advance();
      sample();
      #1 RST = 1'b1;
      #1;
      n_checks++;
      if (ram_ren !== 1'b0 || ram_addr !== 32'h0 || err !== 1'b0 ||
          iwait !== 1'b1 || iload !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_async: ren=%b addr=%h err=%b iwait=%b iload=%h expected 0 0 0 1 0",
                  ram_ren, ram_addr, err, iwait, iload);
      end
      advance();
      iREN = 1'b0;
      RST  = 1'b0;
      sample();
      n_checks++;
      if (ram_ren !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_after: ren=%b err=%b expected 0 0", ram_ren, err);
      end
      advance();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_tie();
      test_starve();
      test_store();
      test_back_to_back();
      test_timeout();
      test_abort();
      test_rst_mid();
      n_checks++;
      if (sb_i.size() != 0 || sb_d.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d fetch and %0d data expectations left, expected 0",
                  sb_i.size(), sb_d.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
